vx_mem_sim_ram: RTL and testbench

Parametrised behavioural memory model for simulation testbenches. It attaches directly to the Vortex memory request/response bus and bypasses the AXI/AHB bridges. It supports:
- full-line reads and writes with per-byte enables;
- a programmable fixed read latency;
- up to OUTSTANDING in-flight reads, returned in order with tag preservation and response backpressure;
- optional write acknowledgements.

---
 rtl/vx_mem_sim_pkg.sv | 25 ++
 rtl/vx_mem_sim_ram_rsp_queue.sv | 79 +++++++
 rtl/vx_mem_sim_ram.sv | 97 +++++++++
 tb/tb_vx_mem_sim_ram.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vx_mem_sim_pkg.sv
// Shared types and helpers for the simulation memory model and its response queue.
package vx_mem_sim_pkg;

  localparam int unsigned CD_W = 8;

  typedef logic [CD_W-1:0] countdown_t;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_kind_e;

  // Pointer width for n entries; never below 1 so single-entry sizes still elaborate.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

  function automatic int unsigned bytes_of(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/vx_mem_sim_ram_rsp_queue.sv
// In-order response FIFO; every live entry counts down to zero, only the head may leave.
module vx_mem_sim_rsp_queue
  import vx_mem_sim_pkg::*;
#(
  parameter  int unsigned DATA_W  = 512,
  parameter  int unsigned TAG_W   = 8,
  parameter  int unsigned ENTRIES = 4,
  localparam int unsigned EW      = DATA_W + TAG_W + CD_W,
  localparam int unsigned PW      = clog2_min1(ENTRIES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [EW-1:0] i_push_entry,
  input  logic          i_pop,
  output logic [EW-1:0] o_head,
  output logic          o_head_ripe,
  output logic [PW:0]   o_count,
  output logic          o_full
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    countdown_t        countdown;
  } rsp_entry_t;

  rsp_entry_t           r_slot [ENTRIES];
  logic [PW-1:0]        r_rd_ptr;
  logic [PW-1:0]        r_wr_ptr;
  logic [PW:0]          r_count;
  logic [ENTRIES-1:0]   w_live;
  logic                 w_push;
  logic                 w_pop;
  rsp_entry_t           w_head;

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    w_live = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      w_live[i] = ({1'b0, PW'(i) - r_rd_ptr} < r_count);
    end
  end

  assign w_push      = i_push && !o_full;
  assign w_pop       = i_pop && (r_count != '0);
  assign w_head      = (r_count != '0) ? r_slot[r_rd_ptr] : '0;
  assign o_head      = w_head;
  assign o_head_ripe = (r_count != '0) && (w_head.countdown == '0);
  assign o_count     = r_count;
  assign o_full      = (r_count == (PW+1)'(ENTRIES));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: occupancy alone decides which slots matter.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (w_live[i] && (r_slot[i].countdown != '0)) begin
        r_slot[i].countdown <= r_slot[i].countdown - 1'b1;
      end
    end
    if (w_push) r_slot[r_wr_ptr] <= i_push_entry;
  end

endmodule

// File: rtl/vx_mem_sim_ram.sv
// Behavioural line memory on the Vortex mem request/response bus with fixed read latency.
module vx_mem_sim_ram
  import vx_mem_sim_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 26,
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned TAG_WIDTH   = 8,
  parameter int unsigned DEPTH       = 65536,
  parameter int unsigned LATENCY     = 8,
  parameter int unsigned OUTSTANDING = 4,
  parameter int unsigned WRITE_ACK   = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              mem_req_valid,
  output logic                              mem_req_ready,
  input  logic                              mem_req_rw,
  input  logic [DATA_WIDTH/8-1:0]           mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]             mem_req_addr,
  input  logic [DATA_WIDTH-1:0]             mem_req_data,
  input  logic [TAG_WIDTH-1:0]              mem_req_tag,
  output logic                              mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]             mem_rsp_data,
  output logic [TAG_WIDTH-1:0]              mem_rsp_tag,
  input  logic                              mem_rsp_ready,
  output logic [clog2_min1(OUTSTANDING):0]  inflight
);

  localparam int unsigned BYTES = bytes_of(DATA_WIDTH);
  localparam int unsigned IDX_W = clog2_min1(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
    countdown_t            countdown;
  } rsp_entry_t;

  logic [DATA_WIDTH-1:0] r_store [DEPTH] = '{default: '0};

  logic [IDX_W-1:0] w_idx;
  req_kind_e        w_kind;
  logic             w_fire;
  logic             w_wr;
  logic             w_rd;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_ripe;
  rsp_entry_t       w_entry;
  rsp_entry_t       w_head;
  logic             w_unused;

  // Upper address bits alias onto the same line.
  assign w_idx  = mem_req_addr[IDX_W-1:0];
  assign w_kind = req_kind_e'(mem_req_rw);
  assign w_fire = mem_req_valid && mem_req_ready;
  assign w_wr   = w_fire && (w_kind == REQ_WR);
  assign w_rd   = w_fire && (w_kind == REQ_RD);
  assign w_push = w_rd || ((WRITE_ACK != 0) && w_wr);

  assign w_entry.data      = w_rd ? r_store[w_idx] : '0;
  assign w_entry.tag       = mem_req_tag;
  assign w_entry.countdown = countdown_t'(LATENCY - 1);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (mem_req_byteen[b]) r_store[w_idx][b*8 +: 8] <= mem_req_data[b*8 +: 8];
      end
    end
  end

  vx_mem_sim_rsp_queue #(
    .DATA_W  (DATA_WIDTH),
    .TAG_W   (TAG_WIDTH),
    .ENTRIES (OUTSTANDING)
  ) u_rsp_queue (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_entry (w_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_head_ripe  (w_ripe),
    .o_count      (inflight),
    .o_full       (w_full)
  );

  assign mem_req_ready = !w_full;
  assign mem_rsp_valid = w_ripe;
  assign mem_rsp_data  = w_head.data;
  assign mem_rsp_tag   = w_head.tag;
  assign w_pop         = mem_rsp_valid && mem_rsp_ready;
  assign w_unused      = ^{w_head.countdown, mem_req_addr};

endmodule

// File: tb/tb_vx_mem_sim_ram.sv
// Directed bench: one DUT without write acks (LATENCY 8), one with write acks (LATENCY 3).
module tb_vx_mem_sim_ram;

  localparam logic [63:0] PAT_A = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] PAT_B = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] PAT_C = 64'h1122_3344_5566_7788;

  logic        clk = 1'b0;
  logic        reset;

  logic        req_valid, req_ready, req_rw, rsp_valid, rsp_ready;
  logic [7:0]  req_byteen, req_tag, rsp_tag;
  logic [25:0] req_addr;
  logic [63:0] req_data, rsp_data;
  logic [2:0]  inflight;

  logic        b_req_valid, b_req_ready, b_req_rw, b_rsp_valid, b_rsp_ready;
  logic [7:0]  b_req_byteen, b_req_tag, b_rsp_tag;
  logic [25:0] b_req_addr;
  logic [63:0] b_req_data, b_rsp_data;
  logic [2:0]  b_inflight;

  int n_cmp = 0;
  int n_bad = 0;
  int max_infl = 0;
  int n;

  always #5 clk = ~clk;

  vx_mem_sim_ram #(
    .ADDR_WIDTH(26), .DATA_WIDTH(64), .TAG_WIDTH(8), .DEPTH(16),
    .LATENCY(8), .OUTSTANDING(4), .WRITE_ACK(0), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(req_valid), .mem_req_ready(req_ready), .mem_req_rw(req_rw),
    .mem_req_byteen(req_byteen), .mem_req_addr(req_addr), .mem_req_data(req_data),
    .mem_req_tag(req_tag), .mem_rsp_valid(rsp_valid), .mem_rsp_data(rsp_data),
    .mem_rsp_tag(rsp_tag), .mem_rsp_ready(rsp_ready), .inflight(inflight)
  );

  vx_mem_sim_ram #(
    .ADDR_WIDTH(26), .DATA_WIDTH(64), .TAG_WIDTH(8), .DEPTH(16),
    .LATENCY(3), .OUTSTANDING(4), .WRITE_ACK(1), .INIT_FILE("")
  ) dut_ack (
    .clk(clk), .reset(reset),
    .mem_req_valid(b_req_valid), .mem_req_ready(b_req_ready), .mem_req_rw(b_req_rw),
    .mem_req_byteen(b_req_byteen), .mem_req_addr(b_req_addr), .mem_req_data(b_req_data),
    .mem_req_tag(b_req_tag), .mem_rsp_valid(b_rsp_valid), .mem_rsp_data(b_rsp_data),
    .mem_rsp_tag(b_rsp_tag), .mem_rsp_ready(b_rsp_ready), .inflight(b_inflight)
  );

  always @(negedge clk) if (int'(inflight) > max_infl) max_infl = int'(inflight);

  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", t, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req0(input logic rw, input logic [25:0] a, input logic [7:0] be,
                      input logic [63:0] d, input logic [7:0] t);
    req_rw = rw; req_addr = a; req_byteen = be; req_data = d; req_tag = t;
    req_valid = 1'b1;
    chk("req_ready", req_ready, 1);
    tick;
    req_valid = 1'b0;
  endtask

  task automatic req1(input logic rw, input logic [25:0] a, input logic [7:0] be,
                      input logic [63:0] d, input logic [7:0] t);
    b_req_rw = rw; b_req_addr = a; b_req_byteen = be; b_req_data = d; b_req_tag = t;
    b_req_valid = 1'b1;
    chk("ack_req_ready", b_req_ready, 1);
    tick;
    b_req_valid = 1'b0;
  endtask

  task automatic wait0(output int cnt);
    cnt = 0;
    while (!rsp_valid && cnt < 40) begin tick; cnt++; end
    chk("rsp_seen", rsp_valid, 1);
  endtask

  task automatic wait1(output int cnt);
    cnt = 0;
    while (!b_rsp_valid && cnt < 40) begin tick; cnt++; end
    chk("ack_rsp_seen", b_rsp_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req_valid = 0; req_rw = 0; req_byteen = '0; req_addr = '0; req_data = '0; req_tag = '0;
    b_req_valid = 0; b_req_rw = 0; b_req_byteen = '0; b_req_addr = '0; b_req_data = '0; b_req_tag = '0;
    rsp_ready = 1'b1; b_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_valid", rsp_valid, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_data", rsp_data, 0);
    chk("rst_tag", rsp_tag, 0);
    chk("ack_rst_valid", b_rsp_valid, 0);

    // full-line write then read: first valid 7 edges after the accept edge
    req0(1, 26'h10, 8'hFF, PAT_A, 8'd0);
    req0(0, 26'h10, 8'h00, 64'd0, 8'd5);
    wait0(n);
    chk("t1_lat", n, 7);
    chk("t1_data", rsp_data, PAT_A);
    chk("t1_tag", rsp_tag, 5);
    tick;
    chk("t1_drain_valid", rsp_valid, 0);
    chk("t1_drain_infl", inflight, 0);

    // partial byte-enable write
    req0(1, 26'h20, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'd0);
    req0(1, 26'h20, 8'h01, 64'd0, 8'd0);
    req0(0, 26'h20, 8'h00, 64'd0, 8'd6);
    wait0(n);
    chk("t2_lat", n, 7);
    chk("t2_data", rsp_data, 64'hFFFF_FFFF_FFFF_FF00);
    chk("t2_tag", rsp_tag, 6);
    tick;

    // aliasing modulo DEPTH=16
    req0(1, 26'h3, 8'hFF, PAT_B, 8'd0);
    req0(0, 26'h13, 8'h00, 64'd0, 8'd9);
    wait0(n);
    chk("alias_data", rsp_data, PAT_B);
    chk("alias_tag", rsp_tag, 9);
    tick;

    // fill the queue under response backpressure
    rsp_ready = 1'b0;
    req_rw = 1'b0; req_byteen = '0; req_data = '0; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = (i % 2 == 1) ? 26'h20 : 26'h3;
      req_tag  = 8'(i + 1);
      tick;
      chk("bp_infl", inflight, 64'(i + 1));
    end
    chk("bp_ready_full", req_ready, 0);
    req_addr = 26'h13; req_tag = 8'd5;
    for (int k = 1; k <= 20; k++) begin
      tick;
      chk("bp_infl_hold", inflight, 4);
      if (k >= 4) begin
        chk("bp_valid", rsp_valid, 1);
        chk("bp_tag", rsp_tag, 1);
      end else begin
        chk("bp_not_ripe", rsp_valid, 0);
      end
    end
    chk("bp_data", rsp_data, PAT_B);

    // pop while full: the offered push waits one cycle
    rsp_ready = 1'b1;
    tick;
    chk("pp_infl_pop", inflight, 3);
    chk("pp_tag2", rsp_tag, 2);
    chk("pp_data2", rsp_data, 64'hFFFF_FFFF_FFFF_FF00);
    chk("pp_ready", req_ready, 1);
    tick;
    req_valid = 1'b0;
    chk("pp_infl_pushpop", inflight, 3);
    chk("pp_tag3", rsp_tag, 3);
    tick;
    chk("pp_tag4", rsp_tag, 4);
    chk("pp_infl2", inflight, 2);
    tick;
    chk("pp_infl1", inflight, 1);
    chk("pp_tag5_not_ripe", rsp_valid, 0);
    wait0(n);
    chk("pp_tag5_wait", n, 5);
    chk("pp_tag5", rsp_tag, 5);
    chk("pp_data5", rsp_data, PAT_B);
    tick;
    chk("pp_empty", inflight, 0);
    chk("max_inflight", max_infl, 4);

    // reset with three reads pending
    req0(0, 26'h3, 8'h00, 64'd0, 8'd7);
    req0(0, 26'h3, 8'h00, 64'd0, 8'd8);
    req0(0, 26'h3, 8'h00, 64'd0, 8'd9);
    chk("rr_infl_pre", inflight, 3);
    reset = 1'b1;
    tick;
    chk("rr_valid", rsp_valid, 0);
    chk("rr_infl", inflight, 0);
    chk("rr_tag", rsp_tag, 0);
    reset = 1'b0;
    repeat (10) tick;
    chk("rr_no_stale", rsp_valid, 0);
    req0(0, 26'h3, 8'h00, 64'd0, 8'd10);
    wait0(n);
    chk("rr_lat", n, 7);
    chk("rr_data_kept", rsp_data, PAT_B);
    chk("rr_tag_new", rsp_tag, 10);
    tick;

    // write acknowledgements
    req1(1, 26'h5, 8'hFF, PAT_C, 8'h42);
    chk("ack_infl", b_inflight, 1);
    wait1(n);
    chk("ack_lat", n, 2);
    chk("ack_tag", b_rsp_tag, 8'h42);
    chk("ack_data", b_rsp_data, 0);
    tick;
    chk("ack_drain", b_inflight, 0);
    req1(0, 26'h5, 8'h00, 64'd0, 8'h43);
    wait1(n);
    chk("ack_rd_lat", n, 2);
    chk("ack_rd_data", b_rsp_data, PAT_C);
    chk("ack_rd_tag", b_rsp_tag, 8'h43);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
